// File: rtl/cond_unit_pkg.sv
// rtl/cond_unit_pkg.sv - shared flag indices, condition codes and FSM state type
// Purpose : common types for the flags consumer and condition evaluator.
// Contents: EQ/LT flag bit indices, cond_e condition codes, FSM state enum,
//           helper telling which conditions ignore in-flight flag writes.
package cond_unit_pkg;

  localparam int FLAG_W = 2;
  localparam int EQ     = 0;
  localparam int LT     = 1;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_LT = 3'd3,
    COND_GE = 3'd4,
    COND_LE = 3'd5,
    COND_GT = 3'd6,
    COND_NV = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // AL and NV do not read the flags, so they never need to wait.
  function automatic logic cond_flag_free(cond_e c);
    return (c == COND_AL) || (c == COND_NV);
  endfunction

endpackage

// File: rtl/cond_unit_if.sv
// rtl/cond_unit_if.sv - request/response handshake bundle for condition evaluation
// Purpose : groups the valid/ready request and response channels.
// Signals : req_valid/req_ready/req_cond/req_tag (request),
//           resp_valid/resp_ready/resp_taken/resp_tag (response).
// Modports: master = requester (branch/cond-instr control), slave = cond_unit.
interface cond_unit_if import cond_unit_pkg::*; #(
  parameter int TAG_W = 4
) ();

  logic             req_valid;
  logic             req_ready;
  cond_e            req_cond;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_taken;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_cond, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_taken, resp_tag
  );

  modport slave (
    input  req_valid, req_cond, req_tag, resp_ready,
    output req_ready, resp_valid, resp_taken, resp_tag
  );

endinterface

// File: rtl/cond_unit_eval.sv
// rtl/cond_unit_eval.sv - combinational condition evaluator (module cond_eval)
// Purpose: decides whether a condition code holds for a given flag pair.
// Ports  : flags[1:0] (indexed EQ/LT), cond (cond_e) -> taken.
// Shared with the decode-stage cond-instr squash logic.
module cond_eval import cond_unit_pkg::*; (
  input  logic [FLAG_W-1:0] flags,
  input  cond_e             cond,
  output logic              taken
);

  logic w_eq;
  logic w_lt;

  assign w_eq = flags[EQ];
  assign w_lt = flags[LT];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = w_eq;
      COND_NE: taken = !w_eq;
      COND_LT: taken = w_lt;
      COND_GE: taken = !w_lt;
      COND_LE: taken = w_lt | w_eq;
      COND_GT: taken = !w_lt & !w_eq;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - architectural flags register, in-flight write tracker and condition FSM
// Purpose : holds EQ/LT flags, counts outstanding flag writes and answers
//           condition requests once no flag write is pending.
// Ports   : clk, rst (sync, active high); flags_pend, flags_wr_en, flags_wr,
//           flags_kill from execute; bus (cond_unit_if.slave) request/response;
//           flags_q current flags; pend_ovf sticky counter saturation flag.
// Config  : COND_FWD_EN enables same-cycle forwarding of flags_wr into
//           readiness and evaluation.
module cond_unit import cond_unit_pkg::*; #(
  parameter int PEND_W = 3,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flags_pend,
  input  logic              flags_wr_en,
  input  logic [FLAG_W-1:0] flags_wr,
  input  logic              flags_kill,
  cond_unit_if.slave        bus,
  output logic [FLAG_W-1:0] flags_q,
  output logic              pend_ovf
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_INC = PEND_W'(1);

  logic [FLAG_W-1:0] r_flags;
  logic [PEND_W-1:0] r_cnt;
  logic              r_ovf;
  state_e            r_state;
  cond_e             r_cond;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_taken;
  logic [TAG_W-1:0]  r_resp_tag;

  logic              w_ready;
  logic [FLAG_W-1:0] w_eval_flags;
  cond_e             w_cond;
  logic              w_taken;
  logic              w_accept;

`ifdef COND_FWD_EN
  // The last outstanding write landing this cycle releases the wait at once.
  assign w_ready      = (r_cnt == '0) ||
                        ((r_cnt == CNT_INC) && flags_wr_en && !flags_pend);
  assign w_eval_flags = flags_wr_en ? flags_wr : r_flags;
`else
  assign w_ready      = (r_cnt == '0);
  assign w_eval_flags = r_flags;
`endif

  // In IDLE the incoming code is evaluated directly; later the latched one.
  assign w_cond   = (r_state == ST_IDLE) ? bus.req_cond : r_cond;
  assign w_accept = bus.req_valid && r_req_ready;

  cond_eval u_eval (
    .flags (w_eval_flags),
    .cond  (w_cond),
    .taken (w_taken)
  );

  // Flags register and in-flight write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (flags_wr_en) begin
        r_flags <= flags_wr;
      end
      if (flags_kill) begin
        r_cnt <= '0;
      end else begin
        case ({flags_pend, flags_wr_en})
          2'b10: begin
            if (r_cnt == CNT_MAX) r_ovf <= 1'b1;
            else                  r_cnt <= r_cnt + CNT_INC;
          end
          2'b01: begin
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_INC;
          end
          default: ;
        endcase
      end
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cond       <= COND_AL;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_taken <= 1'b0;
      r_resp_tag   <= '0;
    end else if (flags_kill) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cond      <= bus.req_cond;
            r_resp_tag  <= bus.req_tag;
            r_req_ready <= 1'b0;
            if (w_ready || cond_flag_free(bus.req_cond)) begin
              r_resp_taken <= w_taken;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_ready) begin
            r_resp_taken <= w_taken;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_taken = r_resp_taken;
  assign bus.resp_tag   = r_resp_tag;
  assign flags_q        = r_flags;
  assign pend_ovf       = r_ovf;

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit
module tb_cond_unit;
  import cond_unit_pkg::*;

  localparam int PEND_W  = 3;
  localparam int TAG_W   = 4;
  localparam int CNT_CAP = (1 << PEND_W) - 1;
`ifdef COND_FWD_EN
  localparam int REL = 1;
`else
  localparam int REL = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flags_pend;
  logic             flags_wr_en;
  logic [1:0]       flags_wr;
  logic             flags_kill;
  logic [1:0]       flags_q;
  logic             pend_ovf;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_flags;
  int         m_cnt;
  bit         m_ovf;

  cond_unit_if #(.TAG_W(TAG_W)) bus ();

  cond_unit #(.PEND_W(PEND_W), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flags_pend  (flags_pend),
    .flags_wr_en (flags_wr_en),
    .flags_wr    (flags_wr),
    .flags_kill  (flags_kill),
    .bus         (bus),
    .flags_q     (flags_q),
    .pend_ovf    (pend_ovf)
  );

  always #5 clk = ~clk;

  // Condition truth table: f[0]=EQ, f[1]=LT.
  function automatic bit m_cond(int c, logic [1:0] f);
    bit eq = f[0];
    bit lt = f[1];
    case (c)
      0: return 1'b1;
      1: return eq;
      2: return !eq;
      3: return lt;
      4: return !lt;
      5: return lt || eq;
      6: return !lt && !eq;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flags_pend     = 1'b0;
    flags_wr_en    = 1'b0;
    flags_wr       = 2'b00;
    flags_kill     = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_cond   = COND_AL;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_flags = 2'b00;
    m_cnt   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic pend_pulse();
    flags_pend = 1'b1;
    tick();
    flags_pend = 1'b0;
    if (m_cnt == CNT_CAP) m_ovf = 1'b1;
    else                  m_cnt++;
  endtask

  task automatic write_flags(input logic [1:0] v);
    flags_wr_en = 1'b1;
    flags_wr    = v;
    tick();
    flags_wr_en = 1'b0;
    m_flags     = v;
    if (m_cnt > 0) m_cnt--;
  endtask

  task automatic send_req(input int c, input logic [TAG_W-1:0] tag);
    bus.req_valid = 1'b1;
    bus.req_cond  = cond_e'(c);
    bus.req_tag   = tag;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++; if (flags_q !== 2'b00) begin errors++; $display("FAIL reset_flags_q got %b exp 00", flags_q); end
    checks++; if (pend_ovf !== 1'b0) begin errors++; $display("FAIL reset_pend_ovf got %b exp 0", pend_ovf); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
    checks++; if (bus.resp_taken !== 1'b0) begin errors++; $display("FAIL reset_resp_taken got %b exp 0", bus.resp_taken); end
    checks++; if (bus.resp_tag !== 4'd0) begin errors++; $display("FAIL reset_resp_tag got %0d exp 0", bus.resp_tag); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
  endtask

  task automatic test_basic();
    write_flags(2'b01);
    send_req(2, 4'd5);
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus.resp_valid); end
    checks++; if (bus.resp_taken !== 1'b0) begin errors++; $display("FAIL basic_taken got %b exp 0", bus.resp_taken); end
    checks++; if (bus.resp_tag !== 4'd5) begin errors++; $display("FAIL basic_tag got %0d exp 5", bus.resp_tag); end
    checks++; if (flags_q !== 2'b01) begin errors++; $display("FAIL basic_flags_q got %b exp 01", flags_q); end
    consume();
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL basic_release got valid=%b ready=%b exp 0/1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_wait_release();
    pend_pulse();
    send_req(3, 4'd9);
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL wait_enter got valid=%b ready=%b exp 0/0", bus.resp_valid, bus.req_ready); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL wait_hold got %b exp 0", bus.resp_valid); end
    write_flags(2'b10);
    for (int i = 1; i <= REL; i++) begin
      if (i > 1) tick();
      checks++; if (bus.resp_valid !== (i == REL)) begin errors++; $display("FAIL wait_latency cycle %0d got %b exp %b", i, bus.resp_valid, (i == REL)); end
    end
    checks++; if (bus.resp_taken !== 1'b1 || bus.resp_tag !== 4'd9) begin errors++; $display("FAIL wait_result got taken=%b tag=%0d exp 1/9", bus.resp_taken, bus.resp_tag); end
    consume();
  endtask

  task automatic test_fwd_same_cycle();
    pend_pulse();
    flags_wr_en = 1'b1;
    flags_wr    = 2'b00;
    send_req(6, 4'd12);
    flags_wr_en = 1'b0;
    m_flags = 2'b00;
    m_cnt   = 0;
    for (int i = 1; i <= REL; i++) begin
      if (i > 1) tick();
      checks++; if (bus.resp_valid !== (i == REL)) begin errors++; $display("FAIL samecyc_latency cycle %0d got %b exp %b", i, bus.resp_valid, (i == REL)); end
    end
    checks++; if (bus.resp_taken !== 1'b1 || bus.resp_tag !== 4'd12) begin errors++; $display("FAIL samecyc_result got taken=%b tag=%0d exp 1/12", bus.resp_taken, bus.resp_tag); end
    consume();
  endtask

  task automatic test_kill();
    pend_pulse();
    send_req(1, 4'd3);
    flags_kill  = 1'b1;
    flags_wr_en = 1'b1;
    flags_wr    = 2'b11;
    tick();
    flags_kill  = 1'b0;
    flags_wr_en = 1'b0;
    m_cnt   = 0;
    m_flags = 2'b11;
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL kill_idle got ready=%b valid=%b exp 1/0", bus.req_ready, bus.resp_valid); end
    checks++; if (flags_q !== 2'b11) begin errors++; $display("FAIL kill_flags_q got %b exp 11", flags_q); end
    tick();
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL kill_no_resp got %b exp 0", bus.resp_valid); end
    send_req(1, 4'd4);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_taken !== 1'b1 || bus.resp_tag !== 4'd4) begin errors++; $display("FAIL kill_count_zero got valid=%b taken=%b tag=%0d exp 1/1/4", bus.resp_valid, bus.resp_taken, bus.resp_tag); end
    consume();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) pend_pulse();
    checks++; if (pend_ovf !== m_ovf) begin errors++; $display("FAIL ovf_set got %b exp %b", pend_ovf, m_ovf); end
    flags_pend  = 1'b1;
    flags_wr_en = 1'b1;
    flags_wr    = 2'b00;
    tick();
    flags_pend  = 1'b0;
    flags_wr_en = 1'b0;
    m_flags = 2'b00;
    for (int i = 0; i < CNT_CAP - 1; i++) write_flags(2'b00);
    send_req(5, 4'd7);
    tick();
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL ovf_count_held got valid=%b exp 0 (model count %0d)", bus.resp_valid, m_cnt); end
    write_flags(2'b01);
    for (int i = 1; i <= REL; i++) begin
      if (i > 1) tick();
      checks++; if (bus.resp_valid !== (i == REL)) begin errors++; $display("FAIL ovf_release cycle %0d got %b exp %b", i, bus.resp_valid, (i == REL)); end
    end
    checks++; if (bus.resp_taken !== m_cond(5, m_flags) || bus.resp_tag !== 4'd7) begin errors++; $display("FAIL ovf_result got taken=%b tag=%0d exp %b/7", bus.resp_taken, bus.resp_tag, m_cond(5, m_flags)); end
    consume();
    checks++; if (pend_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", pend_ovf); end
    do_reset();
    checks++; if (pend_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", pend_ovf); end
  endtask

  task automatic test_al_nv();
    pend_pulse();
    pend_pulse();
    send_req(0, 4'd1);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_taken !== 1'b1 || bus.resp_tag !== 4'd1) begin errors++; $display("FAIL al_nowait got valid=%b taken=%b tag=%0d exp 1/1/1", bus.resp_valid, bus.resp_taken, bus.resp_tag); end
    consume();
    send_req(7, 4'd2);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_taken !== 1'b0 || bus.resp_tag !== 4'd2) begin errors++; $display("FAIL nv_nowait got valid=%b taken=%b tag=%0d exp 1/0/2", bus.resp_valid, bus.resp_taken, bus.resp_tag); end
    consume();
    write_flags(2'b10);
    write_flags(2'b00);
  endtask

  task automatic test_resp_hold();
    bit exp_t;
    exp_t = m_cond(4, m_flags);
    send_req(4, 4'd10);
    bus.req_valid = 1'b1;
    bus.req_cond  = COND_NV;
    bus.req_tag   = 4'd3;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_taken !== exp_t || bus.resp_tag !== 4'd10 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL hold_stable cycle %0d got valid=%b taken=%b tag=%0d ready=%b exp 1/%b/10/0", i, bus.resp_valid, bus.resp_taken, bus.resp_tag, bus.req_ready, exp_t); end
      tick();
    end
    bus.req_valid = 1'b0;
    consume();
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%b ready=%b exp 0/1", bus.resp_valid, bus.req_ready); end
    send_req(7, 4'd11);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_taken !== 1'b0 || bus.resp_tag !== 4'd11) begin errors++; $display("FAIL hold_next_req got valid=%b taken=%b tag=%0d exp 1/0/11", bus.resp_valid, bus.resp_taken, bus.resp_tag); end
    consume();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int               k;
      int               c;
      logic [TAG_W-1:0] tag;
      bit               immediate;
      k   = $urandom_range(0, 2);
      c   = $urandom_range(0, 7);
      tag = TAG_W'($urandom);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready it %0d got %b exp 1", it, bus.req_ready); end
      for (int p = 0; p < k; p++) pend_pulse();
      immediate = (k == 0) || (c == 0) || (c == 7);
      send_req(c, tag);
      if (immediate) begin
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_taken !== m_cond(c, m_flags) || bus.resp_tag !== tag) begin errors++; $display("FAIL rnd_imm it %0d cond %0d got valid=%b taken=%b tag=%0d exp 1/%b/%0d", it, c, bus.resp_valid, bus.resp_taken, bus.resp_tag, m_cond(c, m_flags), tag); end
        consume();
        for (int w = 0; w < k; w++) write_flags(2'($urandom));
      end else begin
        for (int w = 0; w < k; w++) begin
          int gap;
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) begin
            tick();
            checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rnd_early it %0d got %b exp 0", it, bus.resp_valid); end
          end
          write_flags(2'($urandom));
          if (w < k - 1) begin
            checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rnd_partial it %0d got %b exp 0", it, bus.resp_valid); end
          end
        end
        for (int i = 1; i <= REL; i++) begin
          if (i > 1) tick();
          checks++; if (bus.resp_valid !== (i == REL)) begin errors++; $display("FAIL rnd_latency it %0d cycle %0d got %b exp %b", it, i, bus.resp_valid, (i == REL)); end
        end
        checks++; if (bus.resp_taken !== m_cond(c, m_flags) || bus.resp_tag !== tag) begin errors++; $display("FAIL rnd_result it %0d cond %0d got taken=%b tag=%0d exp %b/%0d", it, c, bus.resp_taken, bus.resp_tag, m_cond(c, m_flags), tag); end
        consume();
      end
      checks++; if (flags_q !== m_flags) begin errors++; $display("FAIL rnd_flags_q it %0d got %b exp %b", it, flags_q, m_flags); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_release();
    test_fwd_same_cycle();
    test_kill();
    test_overflow();
    test_al_nv();
    test_resp_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
